// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared constants for the divider: default width, FSM state
//            encoding and the divide-by-zero quotient pattern.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef logic [1:0] div_state_t;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // Quotient returned for a zero divisor: all ones, truncated to WIDTH at use.
  localparam logic [63:0] DIVZ_QUO = '1;

endpackage
`default_nettype wire

// File: rtl/div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl_if
// Purpose  : Execute-stage <-> divider bundle (request, operands, stall,
//            completion and results).
// Revision : 1.0 - initial release
// ============================================================================
interface div_ctrl_if import cpu_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             annul;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues requests, consumes results.
  modport master (
    output start, signed_div, opa, opb, annul,
    input  stall, done, hi, lo
  );

  // Divider side.
  modport slave (
    input  start, signed_div, opa, opb, annul,
    output stall, done, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One restoring shift-subtract iteration. The dividend is shifted
//            out of the top of quo_i into the partial remainder while the
//            new quotient bit is shifted into the bottom.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // Trial subtraction; keep the difference only when it does not borrow.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_i};
    ge      = (shifted >= {1'b0, dvsr_i});
    rem_o   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ge};
  end

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Multi-cycle signed/unsigned integer divider for the execute
//            stage. Magnitudes are divided with one restoring step per cycle;
//            signs are applied on the final step as the result is captured.
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl import cpu_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] dvsr_q,  dvsr_d;
  logic             sa_q,    sa_d;
  logic             sb_q,    sb_d;
  logic             sdiv_q,  sdiv_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;

  logic [WIDTH-1:0] opa_abs;
  logic [WIDTH-1:0] opb_abs;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             neg_quo;
  logic             neg_rem;
  logic             last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  // Operand magnitudes; only signed requests take absolute values.
  always_comb begin
    opa_abs = (bus.signed_div && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    opb_abs = (bus.signed_div && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
  end

  // Sign correction of the final step result (quotient follows sign XOR,
  // remainder follows the dividend).
  always_comb begin
    neg_quo   = sdiv_q && (sa_q ^ sb_q);
    neg_rem   = sdiv_q && sa_q;
    quo_fix   = neg_quo ? -step_quo : step_quo;
    rem_fix   = neg_rem ? -step_rem : step_rem;
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state logic: IDLE accepts, BUSY iterates, DONE pulses for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sdiv_d  = sdiv_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      DIV_IDLE: begin
        if (bus.start && !bus.annul) begin
          if (bus.opb == '0) begin
            state_d = DIV_DONE;
            hi_d    = bus.opa;
            lo_d    = WIDTH'(DIVZ_QUO);
          end else begin
            state_d = DIV_BUSY;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = opa_abs;
            dvsr_d  = opb_abs;
            sa_d    = bus.opa[WIDTH-1];
            sb_d    = bus.opb[WIDTH-1];
            sdiv_d  = bus.signed_div;
          end
        end
      end
      DIV_BUSY: begin
        if (bus.annul) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            state_d = DIV_DONE;
            hi_d    = rem_fix;
            lo_d    = quo_fix;
          end
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sdiv_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sdiv_q  <= sdiv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall is combinational so the request cycle itself freezes the pipe;
  // it drops in DONE so the divide instruction retires with its result.
  always_comb begin
    bus.stall = ((state_q == DIV_IDLE) && bus.start) || (state_q == DIV_BUSY);
    bus.done  = (state_q == DIV_DONE);
    bus.hi    = hi_q;
    bus.lo    = lo_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Purpose  : Directed self-checking bench for div_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

  logic clk;
  logic rst;
  int   vec  = 0;
  int   errs = 0;
  int   cyc  = 0;
  int   done_cyc = 0;
  int   t1;
  int   d;

  div_ctrl_if #(.WIDTH(32)) bus ();

  div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a divide from IDLE, holding start while stalled; returns in the
  // done cycle with start released.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input int elat);
    int n;
    int st;
    n  = 0;
    st = 0;
    bus.signed_div = sd;
    bus.opa        = a;
    bus.opb        = b;
    bus.annul      = 1'b0;
    bus.start      = 1'b1;
    #1;
    chk({tag, ".stall_req"}, 32'(bus.stall), 32'd1);
    while (n < 200) begin
      if (bus.stall) st++;
      tick();
      n++;
      if (bus.done) break;
    end
    done_cyc = cyc;
    chk({tag, ".latency"}, 32'(n), 32'(elat));
    chk({tag, ".stall_cycles"}, 32'(st), 32'(elat));
    chk({tag, ".stall_in_done"}, 32'(bus.stall), 32'd0);
    chk({tag, ".hi"}, bus.hi, ehi);
    chk({tag, ".lo"}, bus.lo, elo);
    bus.start = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opa        = '0;
    bus.opb        = '0;
    bus.annul      = 1'b0;
    #1;
    chk("reset.stall", 32'(bus.stall), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.hi", bus.hi, 32'd0);
    chk("reset.lo", bus.lo, 32'd0);
    bus.start = 1'b1;
    #1;
    chk("reset.stall_start", 32'(bus.stall), 32'd1);
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Unsigned and signed divides, including overflow and all-ones dividend.
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    tick();
    chk("post_done.done", 32'(bus.done), 32'd0);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    tick();
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    tick();
    run_div("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 33);
    tick();
    run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 33);
    tick();
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 33);
    tick();
    run_div("div_by_zero", 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
    tick();

    // Annul at BUSY cycle 10: back to IDLE, no done, results untouched.
    bus.signed_div = 1'b0;
    bus.opa        = 32'd1000;
    bus.opb        = 32'd10;
    bus.start      = 1'b1;
    tick();
    repeat (9) tick();
    bus.annul = 1'b1;
    bus.start = 1'b0;
    #1;
    chk("annul.stall_busy", 32'(bus.stall), 32'd1);
    tick();
    bus.annul = 1'b0;
    #1;
    chk("annul.stall", 32'(bus.stall), 32'd0);
    chk("annul.done", 32'(bus.done), 32'd0);
    chk("annul.hi", bus.hi, 32'd5);
    chk("annul.lo", bus.lo, 32'hFFFF_FFFF);

    // Annul in IDLE blocks acceptance of the request.
    bus.opa   = 32'd20;
    bus.opb   = 32'd4;
    bus.start = 1'b1;
    bus.annul = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.annul = 1'b0;
    #1;
    chk("annul_idle.stall", 32'(bus.stall), 32'd0);
    d = 0;
    repeat (40) begin
      tick();
      if (bus.done) d++;
    end
    chk("annul.no_done", 32'(d), 32'd0);
    chk("annul.hi_hold", bus.hi, 32'd5);

    // Annul in DONE does not cut the pulse short.
    bus.opa   = 32'd9;
    bus.opb   = 32'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.annul = 1'b1;
    #1;
    chk("annul_done.done", 32'(bus.done), 32'd1);
    chk("annul_done.hi", bus.hi, 32'd9);
    tick();
    bus.annul = 1'b0;
    #1;
    chk("annul_done.after", 32'(bus.done), 32'd0);
    chk("annul_done.hi_hold", bus.hi, 32'd9);

    // Back-to-back: start ignored in DONE, accepted in the next IDLE.
    run_div("b2b_1", 1'b0, 32'd50, 32'd5, 32'd0, 32'd10, 33);
    t1 = done_cyc;
    bus.opa   = 32'd77;
    bus.opb   = 32'd8;
    bus.start = 1'b1;
    #1;
    chk("b2b.stall_in_done", 32'(bus.stall), 32'd0);
    tick();
    chk("b2b.idle_done", 32'(bus.done), 32'd0);
    run_div("b2b_2", 1'b0, 32'd77, 32'd8, 32'd5, 32'd9, 33);
    chk("b2b.gap", 32'(done_cyc - t1), 32'd34);
    tick();

    // Reset at BUSY cycle 20 abandons the divide.
    bus.opa   = 32'd1234;
    bus.opb   = 32'd3;
    bus.start = 1'b1;
    tick();
    repeat (19) tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("rst_busy.hi", bus.hi, 32'd0);
    chk("rst_busy.lo", bus.lo, 32'd0);
    chk("rst_busy.done", 32'(bus.done), 32'd0);
    chk("rst_busy.stall", 32'(bus.stall), 32'd0);
    tick();
    rst = 1'b1;
    d = 0;
    repeat (50) begin
      tick();
      if (bus.done) d++;
    end
    chk("rst_busy.no_done", 32'(d), 32'd0);
    run_div("after_rst", 1'b0, 32'd1234, 32'd3, 32'd1, 32'd411, 33);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the iteration counter width (must hold WIDTH).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  execute-stage divide request, held by the pipeline while stalled.
REQ-006 The block SHALL have port signed_div  input  1  1 = DIV (signed), 0 = DIVU.
REQ-007 The block SHALL have port opa  input  WIDTH  dividend, forwarded execute-stage source A.
REQ-008 The block SHALL have port opb  input  WIDTH  divisor, forwarded execute-stage source B.
REQ-009 The block SHALL have port annul  input  1  cancel the in-flight divide (execute flush or exception).
REQ-010 The block SHALL have port stall  output  1  freeze fetch/decode/execute while a divide is incomplete.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse; hi/lo valid for hi/lo write.
REQ-012 The block SHALL have port hi  output  WIDTH  remainder.
REQ-013 The block SHALL have port lo  output  WIDTH  quotient.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 In IDLE with start=1 and opb!=0, the block SHALL latch |opa| and |opb| (absolute values only when signed_div=1), latch both sign bits and signed_div, clear the counter and the partial remainder, and enter BUSY.
REQ-016 In IDLE with start=1 and opb==0, the block SHALL enter DONE next cycle with hi=opa and lo={WIDTH{1'b1}}; no iterations run.
REQ-017 In BUSY, the block SHALL perform one restoring shift-subtract step per cycle, increment the counter, and enter DONE after exactly WIDTH steps.
REQ-018 In DONE, the block SHALL set the quotient negated if signed and the operand signs differ, and the remainder negated if signed and the dividend is negative; it SHALL assert done for exactly that cycle and return to IDLE.
REQ-019 Latency SHALL be WIDTH+1 cycles from the start cycle in IDLE to the done cycle (33 for WIDTH=32); divide-by-zero latency SHALL be 1.
REQ-020 stall SHALL be combinational: 1 when (IDLE and start) or BUSY; 0 in DONE so the instruction advances in the done cycle.
REQ-021 start SHALL be ignored in DONE; a back-to-back divide SHALL be accepted in the following IDLE cycle.
REQ-022 annul=1 in BUSY SHALL force IDLE next cycle, with no done pulse and hi/lo unchanged; annul in IDLE SHALL suppress acceptance of start that cycle.
REQ-023 annul in DONE SHALL have no effect: the done pulse completes.
REQ-024 hi/lo SHALL update only on entry to DONE and SHALL hold their value otherwise.
REQ-025 Signed overflow (opa=0x80000000, opb=0xFFFFFFFF) SHALL yield lo=0x80000000, hi=0.

Reset
REQ-026 rst low SHALL immediately force IDLE and clear the counter, the working registers, hi, lo and done to 0.
REQ-027 Because stall is combinational, stall SHALL be 0 during reset unless start=1.
REQ-028 rst asserted mid-BUSY SHALL abandon the divide with no done pulse after reset release.

Structure
REQ-029 State encoding, WIDTH default and divide-by-zero quotient constant SHALL live in shared package cpu_pkg.
REQ-030 One combinational sub-module, div_step, SHALL compute a single shift-subtract iteration: in {rem, quo, divisor}, out {rem, quo}.
REQ-031 div_ctrl SHALL instantiate exactly one div_step; there SHALL be no multi-cycle path.

Verification
REQ-032 Unsigned divide: DIVU 100/7 -> stall high for 33 cycles, done on cycle 33, lo=14, hi=2.
REQ-033 Signed divide: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Divide by zero: opa=5, opb=0 -> done on cycle 1, hi=5, lo=0xFFFFFFFF, stall high for 1 cycle.
REQ-035 Annul: annul pulsed at BUSY cycle 10 -> IDLE next cycle, no done, hi/lo keep prior values, stall drops.
REQ-036 Back-to-back: two DIVU started consecutively -> two done pulses 34 cycles apart, both results correct.
REQ-037 Reset: rst low at BUSY cycle 20 -> hi=lo=0, done=0 and state IDLE immediately; no done pulse after release.
